// File: rtl/control_unit.sv
// Main opcode decoder for the single-cycle MIPS datapath: opcode -> datapath control word.
// Latency: 1 cycle (registered decode). Backpressure: none, a new opcode is accepted every cycle.
// Unsupported or unknown opcodes decode to the all-zero NOP word.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  output logic       regdest,
  output logic       jump,
  output logic       branch,
  output logic       memread,
  output logic       memtoreg,
  output logic       memwrite,
  output logic       alusrc,
  output logic       regwrite,
  output logic [1:0] aluop
);

  typedef struct packed {
    logic       regdest;
    logic       jump;
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] aluop;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  ctrl_t dec;
  ctrl_t ctrl_q;

  // An opcode carrying X/Z matches no item and falls to the NOP default.
  always_comb begin
    dec = '0;
    case (opcode)
      OP_RTYPE: begin
        dec.regdest  = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = 2'b10;
      end
      OP_LW: begin
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
      end
      OP_SW: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.aluop  = 2'b01;
      end
      OP_J: begin
        dec.jump = 1'b1;
      end
      default: dec = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= dec;
    end
  end

  assign regdest  = ctrl_q.regdest;
  assign jump     = ctrl_q.jump;
  assign branch   = ctrl_q.branch;
  assign memread  = ctrl_q.memread;
  assign memtoreg = ctrl_q.memtoreg;
  assign memwrite = ctrl_q.memwrite;
  assign alusrc   = ctrl_q.alusrc;
  assign regwrite = ctrl_q.regwrite;
  assign aluop    = ctrl_q.aluop;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: reset, table rows, glitch, mid-stream reset, sweep, X opcode.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       regdest, jump, branch, memread, memtoreg, memwrite, alusrc, regwrite;
  logic [1:0] aluop;

  int checks = 0;
  int errors = 0;

  // {regdest,jump,branch,memread,memtoreg,memwrite,alusrc,regwrite,aluop}
  localparam logic [9:0] E_NOP = 10'b00000000_00;
  localparam logic [9:0] E_R   = 10'b10000001_10;
  localparam logic [9:0] E_LW  = 10'b00011011_00;
  localparam logic [9:0] E_SW  = 10'b00000110_00;
  localparam logic [9:0] E_BEQ = 10'b00100000_01;
  localparam logic [9:0] E_J   = 10'b01000000_00;

  control_unit dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .regdest  (regdest),
    .jump     (jump),
    .branch   (branch),
    .memread  (memread),
    .memtoreg (memtoreg),
    .memwrite (memwrite),
    .alusrc   (alusrc),
    .regwrite (regwrite),
    .aluop    (aluop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {regdest, jump, branch, memread, memtoreg, memwrite, alusrc, regwrite, aluop};
  endfunction

  function automatic logic [9:0] table_row(input logic [5:0] op);
    case (op)
      6'b000000: return E_R;
      6'b100011: return E_LW;
      6'b101011: return E_SW;
      6'b000100: return E_BEQ;
      6'b000010: return E_J;
      default:   return E_NOP;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    obs = outs();
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    checks++;
    assert (!(memread && memwrite) && !(jump && branch) && !(regwrite && memwrite))
    else begin
      errors++;
      $error("FAIL %s_excl observed=%b expected=no exclusive pair set", tag, obs);
    end
  endtask

  initial begin
    logic [5:0] xop;
    logic [9:0] xexp;

    // Reset held for two edges while lw is presented, then released.
    rst    = 1'b1;
    opcode = 6'b100011;
    tick();
    chk("reset_edge1", E_NOP);
    tick();
    chk("reset_edge2", E_NOP);
    rst = 1'b0;
    tick();
    chk("reset_release_lw", E_LW);

    // Back-to-back table rows, one cycle after sampling.
    opcode = 6'b000000; tick(); chk("seq_rtype", E_R);
    opcode = 6'b100011; tick(); chk("seq_lw", E_LW);
    opcode = 6'b101011; tick(); chk("seq_sw", E_SW);
    opcode = 6'b111111; tick(); chk("seq_nop", E_NOP);
    opcode = 6'b000100; tick(); chk("seq_beq", E_BEQ);
    opcode = 6'b000010; tick(); chk("seq_j", E_J);

    // Opcode glitch between edges must not disturb the held R-type word.
    opcode = 6'b000000; tick(); chk("glitch_base", E_R);
    #1 opcode = 6'b101011;
    #1 chk("glitch_mid", E_R);
    opcode = 6'b000000;
    #1 chk("glitch_back", E_R);
    tick();
    chk("glitch_next_edge", E_R);

    // Reset in the middle of a beq stream.
    opcode = 6'b000100; tick(); chk("midrst_beq", E_BEQ);
    rst = 1'b1;         tick(); chk("midrst_assert", E_NOP);
    rst = 1'b0;         tick(); chk("midrst_release", E_BEQ);

    // Exhaustive sweep of every opcode.
    for (int i = 0; i < 64; i++) begin
      opcode = 6'(i);
      tick();
      chk($sformatf("sweep_%02h", i), table_row(6'(i)));
    end

    // Unknown opcode must decode to a known NOP; a two-state simulator
    // substitutes a concrete value, which then decodes per the table.
    opcode = 6'b000000; tick(); chk("x_pre", E_R);
    opcode = 6'bxxxxxx;
    xop    = opcode;
    xexp   = $isunknown(xop) ? E_NOP : table_row(xop);
    tick();
    chk("x_opcode", xexp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
